// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate byte cache.
// The CPU and the memory both see a read/write/busywait handshake.
module dcache_controller #(
   parameter int NUM_BLOCKS  = 8,
   parameter int BLOCK_BYTES = 4,
   parameter int ADDR_W      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [7:0]        cpu_writedata,
   output logic [7:0]        cpu_readdata,
   output logic              cpu_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_writedata,
   input  logic [7:0]        mem_readdata,
   input  logic              mem_busywait
);

   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int OFF_W = $clog2(BLOCK_BYTES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_BYTES - 1);

   typedef enum logic [1:0] {IDLE, WB, FETCH, UPDATE} state_t;

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic              gap_q, gap_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [TAG_W-1:0]  mtag_q, mtag_d;
   logic [IDX_W-1:0]  midx_q, midx_d;

   logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [7:0]            data_q [NUM_BLOCKS][BLOCK_BYTES];
   logic [7:0]            fill_q [BLOCK_BYTES];

   logic [TAG_W-1:0] tag_w;
   logic [IDX_W-1:0] idx_w;
   logic [OFF_W-1:0] off_w;
   logic             access, hit, done, upd, hit_wr;

   assign tag_w  = cpu_address[ADDR_W-1 -: TAG_W];
   assign idx_w  = cpu_address[OFF_W +: IDX_W];
   assign off_w  = cpu_address[OFF_W-1:0];
   assign access = cpu_read ^ cpu_write;
   assign hit    = valid_q[idx_w] && (tag_q[idx_w] == tag_w);

   assign cpu_busywait  = (state_q != IDLE) || (access && !hit);
   assign cpu_readdata  = (cpu_read && hit) ? data_q[idx_w][off_w] : 8'h00;
   assign mem_read      = rd_q;
   assign mem_write     = wr_q;
   assign mem_address   = addr_q;
   assign mem_writedata = wdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mtag_d  = mtag_q;
      midx_d  = midx_q;
      done    = 1'b0;
      upd     = 1'b0;
      hit_wr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access && !hit) begin
               mtag_d = tag_w;
               midx_d = idx_w;
               cnt_d  = '0;
               gap_d  = 1'b0;
               if (valid_q[idx_w] && dirty_q[idx_w]) begin
                  state_d = WB;
                  wr_d    = 1'b1;
                  addr_d  = {tag_q[idx_w], idx_w, {OFF_W{1'b0}}};
                  wdata_d = data_q[idx_w][0];
               end else begin
                  state_d = FETCH;
                  rd_d    = 1'b1;
                  addr_d  = {tag_w, idx_w, {OFF_W{1'b0}}};
               end
            end else if (access && cpu_write) begin
               hit_wr = 1'b1;
            end
         end
         WB, FETCH: begin
            if (gap_q) begin
               // Re-raise the request after a one-cycle low gap.
               gap_d = 1'b0;
               rd_d  = (state_q == FETCH);
               wr_d  = (state_q == WB);
               if (state_q == WB) begin
                  addr_d  = {tag_q[midx_q], midx_q, cnt_q};
                  wdata_d = data_q[midx_q][cnt_q];
               end else begin
                  addr_d = {mtag_q, midx_q, cnt_q};
               end
            end else if ((rd_q || wr_q) && !mem_busywait) begin
               done  = 1'b1;
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               gap_d = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST)
                  state_d = (state_q == WB) ? FETCH : UPDATE;
            end
         end
         UPDATE: begin
            upd     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gap_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mtag_q  <= '0;
         midx_q  <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mtag_q  <= mtag_d;
         midx_q  <= midx_d;
         if (upd) begin
            valid_q[midx_q] <= 1'b1;
            dirty_q[midx_q] <= 1'b0;
         end
         if (hit_wr)
            dirty_q[idx_w] <= 1'b1;
      end
   end

   // Line storage carries no reset; valid bits gate its use.
   always_ff @(posedge clock) begin
      if (done && state_q == FETCH)
         fill_q[cnt_q] <= mem_readdata;
      if (upd) begin
         tag_q[midx_q] <= mtag_q;
         for (int k = 0; k < BLOCK_BYTES; k++)
            data_q[midx_q][k] <= fill_q[k];
      end
      if (hit_wr)
         data_q[idx_w][off_w] <= cpu_writedata;
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller against a 256x8 memory
// whose busywait falls one edge after each access.
module tb_dcache_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_read = 1'b0, cpu_write = 1'b0;
   logic [7:0] cpu_address = '0, cpu_writedata = '0;
   logic [7:0] cpu_readdata;
   logic       cpu_busywait;
   logic       mem_read, mem_write;
   logic [7:0] mem_address, mem_writedata;
   logic [7:0] mem_readdata = '0;
   logic       mem_busywait;

   dcache_controller dut (
      .clock         (clock),
      .reset         (reset),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .cpu_address   (cpu_address),
      .cpu_writedata (cpu_writedata),
      .cpu_readdata  (cpu_readdata),
      .cpu_busywait  (cpu_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   always #5 clock = ~clock;

   logic [7:0] mem [256];
   logic       served;
   logic       prev_rd;
   logic [8:0] log_a [$];
   logic [7:0] log_d [$];
   int         rd_rise = 0;
   int         both_cnt = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   assign mem_busywait = (mem_read | mem_write) & ~served;

   always @(posedge clock or posedge reset) begin
      if (reset) served <= 1'b0;
      else       served <= mem_read | mem_write;
   end

   always @(posedge clock) begin
      if (!reset && (mem_read | mem_write) && !served) begin
         log_a.push_back({mem_write, mem_address});
         log_d.push_back(mem_writedata);
         if (mem_write) mem[mem_address] <= mem_writedata;
         else           mem_readdata <= mem[mem_address];
      end
      if (mem_read && !prev_rd) rd_rise++;
      if (mem_read && mem_write) both_cnt++;
      prev_rd <= mem_read;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_log();
      log_a.delete();
      log_d.delete();
      rd_rise = 0;
   endtask

   task automatic cpu_access(input logic rd, input logic wr,
                             input logic [7:0] a, input logic [7:0] d,
                             output int stall, output logic [7:0] rdata);
      @(negedge clock);
      cpu_read = rd; cpu_write = wr;
      cpu_address = a; cpu_writedata = d;
      #1;
      stall = 0;
      while (cpu_busywait && stall < 100) begin
         stall++;
         @(negedge clock);
         #1;
      end
      rdata = cpu_readdata;
      @(posedge clock);
      #1;
      cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic check_log(input string tag, input int i,
                            input logic [8:0] ea, input logic [7:0] ed);
      logic [8:0] ga;
      logic [7:0] gd;
      ga = (i < log_a.size()) ? log_a[i] : 9'h1ff;
      gd = (i < log_d.size()) ? log_d[i] : 8'hxx;
      check({tag, "_addr"}, 32'(ga), 32'(ea));
      if (ea[8]) check({tag, "_data"}, 32'(gd), 32'(ed));
   endtask

   int         st;
   logic [7:0] rdv;
   int         w;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_rd", 32'(mem_read), 0);
      check("rst_wr", 32'(mem_write), 0);
      check("rst_addr", 32'(mem_address), 0);
      check("rst_wdata", 32'(mem_writedata), 0);
      check("rst_busy", 32'(cpu_busywait), 0);

      clr_log();
      cpu_access(1, 0, 8'h00, 8'h00, st, rdv);
      check("t1_stall", st, 13);
      check("t1_data", 32'(rdv), 32'h5A);
      check("t1_nacc", log_a.size(), 4);
      check("t1_rise", rd_rise, 4);
      for (int k = 0; k < 4; k++)
         check_log("t1_log", k, 9'(k), 8'h00);

      clr_log();
      cpu_access(1, 0, 8'h01, 8'h00, st, rdv);
      check("t2_stall", st, 0);
      check("t2_data", 32'(rdv), 32'h5B);
      check("t2_nacc", log_a.size(), 0);

      clr_log();
      cpu_access(0, 1, 8'h02, 8'hAB, st, rdv);
      check("t3w_stall", st, 0);
      cpu_access(1, 0, 8'h22, 8'h00, st, rdv);
      check("t3_stall", st, 25);
      check("t3_data", 32'(rdv), 32'h78);
      check("t3_nacc", log_a.size(), 8);
      check_log("t3_wb0", 0, 9'h100, 8'h5A);
      check_log("t3_wb1", 1, 9'h101, 8'h5B);
      check_log("t3_wb2", 2, 9'h102, 8'hAB);
      check_log("t3_wb3", 3, 9'h103, 8'h59);
      for (int k = 0; k < 4; k++)
         check_log("t3_fe", 4 + k, 9'(8'h20 + k), 8'h00);
      check("t3_mem02", 32'(mem[8'h02]), 32'hAB);

      clr_log();
      cpu_access(0, 1, 8'h47, 8'h5C, st, rdv);
      check("t4w_stall", st, 13);
      check("t4_nacc", log_a.size(), 4);
      check_log("t4_fe0", 0, 9'h044, 8'h00);
      check_log("t4_fe3", 3, 9'h047, 8'h00);
      cpu_access(1, 0, 8'h47, 8'h00, st, rdv);
      check("t4r_stall", st, 0);
      check("t4r_data", 32'(rdv), 32'h5C);
      clr_log();
      cpu_access(1, 0, 8'h67, 8'h00, st, rdv);
      check("t4e_stall", st, 25);
      check("t4e_data", 32'(rdv), 32'h3D);
      check_log("t4_wb0", 0, 9'h144, 8'h1E);
      check_log("t4_wb3", 3, 9'h147, 8'h5C);
      check("t4_mem47", 32'(mem[8'h47]), 32'h5C);

      clr_log();
      @(negedge clock);
      cpu_read = 1'b1; cpu_address = 8'h88;
      w = 0;
      while (rd_rise < 3 && w < 50) begin
         @(negedge clock);
         w++;
      end
      check("t5_rise", rd_rise, 3);
      check("t5_rdhi", 32'(mem_read), 1);
      check("t5_addr", 32'(mem_address), 32'h8A);
      reset = 1'b1;
      cpu_read = 1'b0;
      #1;
      check("t5_rdlo", 32'(mem_read), 0);
      check("t5_rstaddr", 32'(mem_address), 0);
      check("t5_busy", 32'(cpu_busywait), 0);
      @(negedge clock);
      reset = 1'b0;
      clr_log();
      cpu_access(1, 0, 8'h88, 8'h00, st, rdv);
      check("t5_restall", st, 13);
      check("t5_data", 32'(rdv), 32'hD2);
      cpu_access(1, 0, 8'h01, 8'h00, st, rdv);
      check("t5_lost", st, 13);

      clr_log();
      @(negedge clock);
      cpu_read = 1'b1; cpu_write = 1'b1;
      cpu_address = 8'hA8; cpu_writedata = 8'hEE;
      #1;
      check("t6_busy_miss", 32'(cpu_busywait), 0);
      repeat (3) @(negedge clock);
      cpu_address = 8'h88;
      #1;
      check("t6_busy_hit", 32'(cpu_busywait), 0);
      repeat (3) @(negedge clock);
      cpu_read = 1'b0; cpu_write = 1'b0;
      check("t6_nacc", log_a.size(), 0);
      cpu_access(1, 0, 8'h88, 8'h00, st, rdv);
      check("t6_tag_stall", st, 0);
      check("t6_nowrite", 32'(rdv), 32'hD2);
      cpu_access(1, 0, 8'hA8, 8'h00, st, rdv);
      check("t6_clean", st, 13);
      check("t6_data", 32'(rdv), 32'hF2);

      check("never_both", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 256x8 byte-wide data memory.
- On the memory side it is the initiator of the read/write/busywait protocol: it drives mem_read/mem_write and waits on mem_busywait.
- On the CPU side it presents the same protocol, so the CPU sees one byte-wide memory with a busywait stall.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (index width log2 = 3).
- BLOCK_BYTES, 4, bytes per line (offset width log2 = 2).
- ADDR_W, 8, byte address width (tag = ADDR_W-5 = 3 bits).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_read  in  1  CPU load request; held until cpu_busywait is low.
- cpu_write  in  1  CPU store request; held until cpu_busywait is low.
- cpu_address  in  8  byte address {tag[7:5], index[4:2], offset[1:0]}.
- cpu_writedata  in  8  store data.
- cpu_readdata  out  8  load data, combinational from the hit line.
- cpu_busywait  out  1  stall to the CPU.
- mem_read  out  1  registered memory read request.
- mem_write  out  1  registered memory write request.
- mem_address  out  8  registered memory byte address.
- mem_writedata  out  8  registered memory write data.
- mem_readdata  in  8  memory read data.
- mem_busywait  in  1  memory busy.

Behaviour:
- Storage: data[8][4] bytes, tag[8] 3 bits, valid[8], dirty[8].
- Reset (async): all valid and dirty bits = 0; state = IDLE; mem_read = mem_write = 0; mem_address = mem_writedata = 0; byte counter = 0. Data contents are don't-care.
- Reset mid-transfer: aborts immediately, requests drop in the same instant, and any dirty data is lost.
- Access decode: access = cpu_read XOR cpu_write. cpu_read and cpu_write both high is illegal; it is treated as no access, busywait stays 0 and no state changes.
- hit = valid[index] && tag[index] == cpu_address[7:5].
- cpu_busywait (combinational) = (state != IDLE) || (access && !hit).
- cpu_readdata (combinational) = data[index][offset] when cpu_read && hit, else 8'h00.
- Read hit: zero-cycle stall; data is valid in the same cycle.
- Write hit: byte is written at the posedge and dirty[index] is set. No stall.
- Miss: taken at the posedge in IDLE. The next state is WB if valid && dirty, else FETCH.
- Memory transaction (one byte), common to WB and FETCH:
  - Phase REQ: mem_read or mem_write = 1, with address and data held stable.
  - A transaction completes at the first posedge where mem_busywait == 0 and the request was already asserted at the previous posedge (minimum one edge of assertion).
  - On completion the request drops. Phase GAP lasts exactly one cycle with both requests low, so the responder sees a fresh request edge.
  - Against a memory whose busywait falls within the cycle after its access edge, each byte costs 3 cycles.
- WB state: writes bytes 0..3 of the victim line to {old_tag, index, k}, k = 0..3 in order. After k = 3 completes, go to FETCH.
- FETCH state: reads {cpu_tag, index, k}, k = 0..3. Each byte is captured into a fill buffer on completion. After k = 3, go to UPDATE.
- UPDATE state: one cycle. Copies the fill buffer into data[index], sets tag = cpu_tag, valid = 1, dirty = 0. Then goes to IDLE.
- In IDLE the pending access now hits. A store then sets dirty.
- CPU address and data must remain stable while cpu_busywait is high. The controller does not latch them, except for the tag and index captured at miss entry, which are used for all memory addresses.
- mem_read and mem_write are never both 1.
- Outside WB and FETCH, both requests are 0.
- Counter wrap: the byte counter is 2 bits and returns to 0 at the end of each WB or FETCH phase.
- Clean-miss latency with a 1-edge memory: 12 cycles (FETCH) + 1 (UPDATE), then hit in IDLE.
- Dirty-miss latency: an additional 12 cycles.

Test Plan:
- Reset, then read 0x00 -> miss. Four mem_read pulses at addresses 0x00..0x03, each separated by a 1-cycle gap, no mem_write. cpu_busywait is high for 13 cycles, then cpu_readdata = memory[0x00].
- Read 0x01 right after test 1 -> hit. cpu_busywait stays 0 and cpu_readdata = memory[0x01] in the same cycle. No memory activity.
- Write 0xAB to 0x02 (hit), then read 0x22 (same index 0, tag 1) -> write-back of 4 bytes to 0x00..0x03 with byte 2 = 0xAB, followed by a fetch from 0x20..0x23. Total stall is 25 cycles.
- Write 0x5C to 0x47 on a cold cache -> fetch of 0x44..0x47, then the store applies. A later eviction writes 0x5C to 0x47.
- Assert reset during the third FETCH byte -> mem_read goes low immediately, state returns to IDLE, and a re-read of the same address misses again.
- cpu_read = cpu_write = 1 -> cpu_busywait = 0, with no memory request and no change to tag, valid or dirty.
